// File: rtl/uio_share_arb.sv
// uio_share_arb: shares the four uio data pads between master 0 (PSRAM quad)
// and master 1 (QSPI). Only one master owns the pads at a time, with a
// round-robin tie-break and a turnaround gap between owners, during which
// all pads are tri-stated.
// Optional macro UIO_SHARE_ARB_TIMEOUT_EN adds a hold counter. When the other
// master has waited MAX_HOLD cycles, the owner is forced off the pads.
module uio_share_arb #(
  parameter int unsigned TURN_CYC = 2,
  parameter int unsigned MAX_HOLD = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req0_i,
  input  logic       req1_i,
  output logic       gnt0_o,
  output logic       gnt1_o,
  input  logic [3:0] m0_sdo_i,
  input  logic [3:0] m0_oe_i,
  input  logic [3:0] m1_sdo_i,
  input  logic [3:0] m1_oe_i,
  output logic [3:0] m0_sdi_o,
  output logic [3:0] m1_sdi_o,
  input  logic [3:0] pad_in_i,
  output logic [3:0] pad_out_o,
  output logic [3:0] pad_oe_o,
  output logic       busy_o,
  output logic       timeout_o
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, TURN} state_t;

  localparam logic [3:0] TURN_LOAD = (TURN_CYC > 0) ? 4'(TURN_CYC - 1) : 4'd0;
  localparam state_t     REL_STATE = (TURN_CYC > 0) ? TURN : IDLE;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic       r_last;
  logic       w_req0;
  logic       w_req1;
  logic       w_force;

`ifdef UIO_SHARE_ARB_TIMEOUT_EN
  localparam logic [15:0] HOLD_LIM = 16'(MAX_HOLD - 1);

  logic [15:0] r_hold;
  logic        r_mask0;
  logic        r_mask1;
  logic        r_tmo;

  // A master is not eligible after a forced release until it deasserts its request.
  assign w_req0 = req0_i & ~r_mask0;
  assign w_req1 = req1_i & ~r_mask1;

  // Force the owner off once the other master has waited MAX_HOLD cycles.
  always_comb begin
    w_force = 1'b0;
    if (r_state == OWN0 && req0_i && w_req1 && r_hold >= HOLD_LIM) w_force = 1'b1;
    if (r_state == OWN1 && req1_i && w_req0 && r_hold >= HOLD_LIM) w_force = 1'b1;
  end

  // Update the hold counter, the request masks and the timeout pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hold  <= '0;
      r_mask0 <= 1'b0;
      r_mask1 <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_tmo <= w_force;
      if ((r_state == OWN0 && w_req1) || (r_state == OWN1 && w_req0)) begin
        if (r_hold != '1) r_hold <= r_hold + 16'd1;
      end else if (r_state != OWN0 && r_state != OWN1) begin
        r_hold <= '0;
      end
      if (r_state == OWN0 && w_force) r_mask0 <= 1'b1;
      else if (!req0_i)               r_mask0 <= 1'b0;
      if (r_state == OWN1 && w_force) r_mask1 <= 1'b1;
      else if (!req1_i)               r_mask1 <= 1'b0;
    end
  end

  assign timeout_o = r_tmo;
`else
  logic w_unused_max_hold;

  assign w_unused_max_hold = (MAX_HOLD == 0);
  assign w_req0            = req0_i;
  assign w_req1            = req1_i;
  assign w_force           = 1'b0;
  assign timeout_o         = 1'b0;
`endif

  // Compute the next ownership state from the requests and the turnaround count.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req0 && w_req1) w_next = r_last ? OWN0 : OWN1;
        else if (w_req0)      w_next = OWN0;
        else if (w_req1)      w_next = OWN1;
      end
      OWN0: if (!req0_i || w_force) w_next = REL_STATE;
      OWN1: if (!req1_i || w_force) w_next = REL_STATE;
      TURN: if (r_cnt == 4'd0) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Register the state, the turnaround counter and the last-served master.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_next == TURN && r_state != TURN) r_cnt <= TURN_LOAD;
      else if (r_state == TURN && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      if (r_state == OWN0 && w_next != OWN0) r_last <= 1'b0;
      if (r_state == OWN1 && w_next != OWN1) r_last <= 1'b1;
    end
  end

  assign gnt0_o = (r_state == OWN0);
  assign gnt1_o = (r_state == OWN1);
  assign busy_o = (r_state != IDLE);

  // Route the pads to the current owner; all pads are tri-stated when there is no owner.
  always_comb begin
    pad_out_o = '0;
    pad_oe_o  = '0;
    m0_sdi_o  = '0;
    m1_sdi_o  = '0;
    if (gnt0_o) begin
      pad_out_o = m0_sdo_i;
      pad_oe_o  = m0_oe_i;
      m0_sdi_o  = pad_in_i;
    end else if (gnt1_o) begin
      pad_out_o = m1_sdo_i;
      pad_oe_o  = m1_oe_i;
      m1_sdi_o  = pad_in_i;
    end
  end

endmodule

// File: tb/tb_uio_share_arb.sv
// Scoreboard bench for uio_share_arb.
// dut uses TURN_CYC=2 and dut0 uses TURN_CYC=0; both see the same inputs.
// Each step pushes the outputs expected after the coming edge. A monitor pops
// them one cycle later and compares them.
module tb_uio_share_arb;

  logic       clk;
  logic       rst;
  logic       req0;
  logic       req1;
  logic [3:0] m0_sdo;
  logic [3:0] m0_oe;
  logic [3:0] m1_sdo;
  logic [3:0] m1_oe;
  logic [3:0] pad_in;

  logic       gnt0, gnt1, busy, tmo;
  logic [3:0] s0, s1, pout, poe;
  logic       z_gnt0, z_gnt1, z_busy, z_tmo;
  logic [3:0] z_s0, z_s1, z_pout, z_poe;

  typedef struct packed {
    logic v;
    logic g0;
    logic g1;
    logic busy;
    logic tmo;
    logic vz;
    logic z0;
    logic z1;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_err;

  uio_share_arb #(.TURN_CYC(2), .MAX_HOLD(8)) dut (
    .clk_i(clk), .rst_i(rst), .req0_i(req0), .req1_i(req1),
    .gnt0_o(gnt0), .gnt1_o(gnt1),
    .m0_sdo_i(m0_sdo), .m0_oe_i(m0_oe), .m1_sdo_i(m1_sdo), .m1_oe_i(m1_oe),
    .m0_sdi_o(s0), .m1_sdi_o(s1), .pad_in_i(pad_in),
    .pad_out_o(pout), .pad_oe_o(poe), .busy_o(busy), .timeout_o(tmo)
  );

  uio_share_arb #(.TURN_CYC(0), .MAX_HOLD(8)) dut0 (
    .clk_i(clk), .rst_i(rst), .req0_i(req0), .req1_i(req1),
    .gnt0_o(z_gnt0), .gnt1_o(z_gnt1),
    .m0_sdo_i(m0_sdo), .m0_oe_i(m0_oe), .m1_sdo_i(m1_sdo), .m1_oe_i(m1_oe),
    .m0_sdi_o(z_s0), .m1_sdi_o(z_s1), .pad_in_i(pad_in),
    .pad_out_o(z_pout), .pad_oe_o(z_poe), .busy_o(z_busy), .timeout_o(z_tmo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the next edge.
  task automatic step(input logic i_rst, input logic i_r0, input logic i_r1,
                      input logic v, input logic g0, input logic g1,
                      input logic b, input logic t,
                      input logic vz, input logic z0, input logic z1);
    exp_t e;
    @(negedge clk);
    rst  = i_rst;
    req0 = i_r0;
    req1 = i_r1;
    e = '{v: v, g0: g0, g1: g1, busy: b, tmo: t, vz: vz, z0: z0, z1: z1};
    sb.push_back(e);
  endtask

  // Pop one expectation per edge and compare it with the sampled outputs.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.v) begin
        check_val("gnt0", {3'b0, gnt0}, {3'b0, e.g0});
        check_val("gnt1", {3'b0, gnt1}, {3'b0, e.g1});
        check_val("busy", {3'b0, busy}, {3'b0, e.busy});
        check_val("timeout", {3'b0, tmo}, {3'b0, e.tmo});
        check_val("excl", {3'b0, gnt0 & gnt1}, 4'h0);
        check_val("pad_out", pout, e.g0 ? 4'h3 : (e.g1 ? 4'hA : 4'h0));
        check_val("pad_oe", poe, e.g0 ? 4'hC : (e.g1 ? 4'hF : 4'h0));
        check_val("m0_sdi", s0, e.g0 ? 4'h5 : 4'h0);
        check_val("m1_sdi", s1, e.g1 ? 4'h5 : 4'h0);
      end
      if (e.vz) begin
        check_val("t0_gnt0", {3'b0, z_gnt0}, {3'b0, e.z0});
        check_val("t0_gnt1", {3'b0, z_gnt1}, {3'b0, e.z1});
        check_val("t0_pad_oe", z_poe, e.z0 ? 4'hC : (e.z1 ? 4'hF : 4'h0));
      end
    end
  end

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst    = 1'b1;
    req0   = 1'b0;
    req1   = 1'b0;
    m0_sdo = 4'h3;
    m0_oe  = 4'hC;
    m1_sdo = 4'hA;
    m1_oe  = 4'hF;
    pad_in = 4'h5;

    // Reset, then a single request from master 0.
    step(1,0,0, 1,0,0,0,0, 1,0,0);
    step(0,0,0, 1,0,0,0,0, 1,0,0);
    step(0,0,0, 1,0,0,0,0, 1,0,0);
    step(0,1,0, 1,1,0,1,0, 1,1,0);
    step(0,1,0, 1,1,0,1,0, 1,1,0);

    // Simultaneous requests: master 0 wins first, then turnaround, then master 1.
    step(1,0,0, 1,0,0,0,0, 1,0,0);
    step(0,1,1, 1,1,0,1,0, 1,1,0);
    step(0,1,1, 1,1,0,1,0, 1,1,0);
    step(0,0,1, 1,0,0,1,0, 1,0,0);
    step(0,0,1, 1,0,0,1,0, 1,0,1);
    step(0,0,1, 1,0,0,0,0, 1,0,1);
    step(0,0,1, 1,0,1,1,0, 1,0,1);
    step(0,0,1, 1,0,1,1,0, 1,0,1);

    // Reset while master 1 owns the pads, then a tie goes to master 0.
    step(1,0,1, 1,0,0,0,0, 1,0,0);
    step(0,1,1, 1,1,0,1,0, 1,1,0);

    // Round robin: once master 0 has been served, master 1 wins the next tie.
    step(0,0,1, 1,0,0,1,0, 1,0,0);
    step(0,1,1, 1,0,0,1,0, 1,0,1);
    step(0,1,1, 1,0,0,0,0, 1,0,1);
    step(0,1,1, 1,0,1,1,0, 1,0,1);
    step(0,0,0, 1,0,0,1,0, 1,0,0);
    step(0,0,0, 1,0,0,1,0, 1,0,0);
    step(0,0,0, 1,0,0,0,0, 1,0,0);

`ifdef UIO_SHARE_ARB_TIMEOUT_EN
    // Forced release after 8 waiting cycles; master 0 stays masked until it drops req0.
    step(1,0,0, 1,0,0,0,0, 0,0,0);
    step(0,1,0, 1,1,0,1,0, 0,0,0);
    repeat (7) step(0,1,1, 1,1,0,1,0, 0,0,0);
    step(0,1,1, 1,0,0,1,1, 0,0,0);
    step(0,1,1, 1,0,0,1,0, 0,0,0);
    step(0,1,1, 1,0,0,0,0, 0,0,0);
    step(0,1,1, 1,0,1,1,0, 0,0,0);
    step(0,1,0, 1,0,0,1,0, 0,0,0);
    step(0,1,0, 1,0,0,1,0, 0,0,0);
    step(0,1,0, 1,0,0,0,0, 0,0,0);
    step(0,1,0, 1,0,0,0,0, 0,0,0);
    step(0,0,0, 1,0,0,0,0, 0,0,0);
    step(0,1,0, 1,1,0,1,0, 0,0,0);
`endif

    // Let the monitor drain the scoreboard, with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    check_val("sb_drain", 4'(sb.size()), 4'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
